// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the MUL/DIV sequencer: ALU function codes, FR flag
// bit positions, op codes and FSM state encodings.
package muldiv_seq_pkg;

  localparam int ALU_FUNC_W = 4;
  localparam logic [ALU_FUNC_W-1:0] ALU_ADD = 4'h0;
  localparam logic [ALU_FUNC_W-1:0] ALU_SUB = 4'h1;

  localparam int FR_FLAG_W = 4;
  localparam int FR_N = 3;
  localparam int FR_Z = 2;
  localparam int FR_C = 1;
  localparam int FR_V = 0;

  localparam logic MD_OP_MULU = 1'b0;
  localparam logic MD_OP_DIVU = 1'b1;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_MUL  = 2'd1,
    MDS_DIV  = 2'd2,
    MDS_DONE = 2'd3
  } md_state_t;

  function automatic logic [FR_FLAG_W-1:0] pack_flags(input logic n, input logic z,
                                                       input logic c, input logic v);
    logic [FR_FLAG_W-1:0] f;
    f       = '0;
    f[FR_N] = n;
    f[FR_Z] = z;
    f[FR_C] = c;
    f[FR_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) sequencer
// that borrows the shared execute-stage ALU while busy.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_W-1:0]     req_a,
  input  logic [DATA_W-1:0]     req_b,
  input  logic                  abort,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_hi,
  output logic [DATA_W-1:0]     res_lo,
  output logic [FR_FLAG_W-1:0]  res_flags,
  output logic                  alu_own,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [ALU_FUNC_W-1:0] alu_func,
  input  logic [DATA_W-1:0]     alu_y,
  input  logic [FR_FLAG_W-1:0]  alu_flags
);

  md_state_t         state;
  logic [CNT_W-1:0]  cnt;
  // hi/lo hold product halves for MULU and remainder/quotient for DIVU
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] opnd;
  logic [FR_FLAG_W-1:0] flags;

  logic              alu_c;
  logic              last_iter;
  logic [DATA_W-1:0] mul_hi_nxt;
  logic [DATA_W-1:0] mul_lo_nxt;
  logic [DATA_W-1:0] div_shift;
  logic              div_ok;
  logic [DATA_W-1:0] div_rem_nxt;
  logic [DATA_W-1:0] div_quo_nxt;
  logic [FR_FLAG_W-1:0] unused_alu_flags;

  assign alu_c            = alu_flags[FR_C];
  assign unused_alu_flags = alu_flags;
  assign last_iter        = (cnt == CNT_W'(DATA_W - 1));

  assign mul_hi_nxt = {alu_c, alu_y[DATA_W-1:1]};
  assign mul_lo_nxt = {alu_y[0], lo[DATA_W-1:1]};

  // The 17th bit of the shifted remainder guarantees the subtract fits
  assign div_shift   = {hi[DATA_W-2:0], lo[DATA_W-1]};
  assign div_ok      = hi[DATA_W-1] | ~alu_c;
  assign div_rem_nxt = div_ok ? alu_y : div_shift;
  assign div_quo_nxt = {lo[DATA_W-2:0], div_ok};

  assign req_ready = (state == MDS_IDLE);
  assign res_hi    = hi;
  assign res_lo    = lo;
  assign res_flags = flags;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_func = ALU_ADD;
    if (state == MDS_MUL) begin
      alu_a    = hi;
      alu_b    = lo[0] ? opnd : '0;
      alu_func = ALU_ADD;
    end else if (state == MDS_DIV) begin
      alu_a    = div_shift;
      alu_b    = opnd;
      alu_func = ALU_SUB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MDS_IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      flags     <= '0;
      res_valid <= 1'b0;
      alu_own   <= 1'b0;
    end else if (abort && (state != MDS_IDLE)) begin
      state     <= MDS_IDLE;
      res_valid <= 1'b0;
      alu_own   <= 1'b0;
    end else begin
      case (state)
        MDS_IDLE: begin
          if (req_valid) begin
            cnt <= '0;
            if (req_op == MD_OP_MULU) begin
              hi      <= '0;
              lo      <= req_a;
              opnd    <= req_b;
              alu_own <= 1'b1;
              state   <= MDS_MUL;
            end else if (req_b != '0) begin
              hi      <= '0;
              lo      <= req_a;
              opnd    <= req_b;
              alu_own <= 1'b1;
              state   <= MDS_DIV;
            end else begin
              hi        <= req_a;
              lo        <= '1;
              flags     <= pack_flags(1'b1, 1'b0, 1'b0, 1'b1);
              res_valid <= 1'b1;
              state     <= MDS_DONE;
            end
          end
        end
        MDS_MUL: begin
          hi  <= mul_hi_nxt;
          lo  <= mul_lo_nxt;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            flags     <= pack_flags(mul_lo_nxt[DATA_W-1],
                                    (mul_hi_nxt == '0) && (mul_lo_nxt == '0),
                                    mul_hi_nxt != '0, 1'b0);
            res_valid <= 1'b1;
            alu_own   <= 1'b0;
            state     <= MDS_DONE;
          end
        end
        MDS_DIV: begin
          hi  <= div_rem_nxt;
          lo  <= div_quo_nxt;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            flags     <= pack_flags(div_quo_nxt[DATA_W-1], div_quo_nxt == '0,
                                    1'b0, 1'b0);
            res_valid <= 1'b1;
            alu_own   <= 1'b0;
            state     <= MDS_DONE;
          end
        end
        MDS_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= MDS_IDLE;
          end
        end
        default: state <= MDS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: behavioural ALU, arithmetic reference
// model, directed corner cases plus randomized MULU/DIVU traffic.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int DATA_W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic                  req_op = 1'b0;
  logic [DATA_W-1:0]     req_a = '0;
  logic [DATA_W-1:0]     req_b = '0;
  logic                  abort = 1'b0;
  logic                  res_valid;
  logic                  res_ready = 1'b0;
  logic [DATA_W-1:0]     res_hi;
  logic [DATA_W-1:0]     res_lo;
  logic [FR_FLAG_W-1:0]  res_flags;
  logic                  alu_own;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic [ALU_FUNC_W-1:0] alu_func;
  logic [DATA_W-1:0]     alu_y;
  logic [FR_FLAG_W-1:0]  alu_flags;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.DATA_W(DATA_W), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .abort(abort),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hi(res_hi), .res_lo(res_lo), .res_flags(res_flags),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_y(alu_y), .alu_flags(alu_flags)
  );

  // Stand-in for the shared ALU: C is carry-out on ADD, borrow on SUB
  always_comb begin
    logic [DATA_W:0] r;
    r = '0;
    if (alu_func == ALU_SUB) r = {1'b0, alu_a} - {1'b0, alu_b};
    else                     r = {1'b0, alu_a} + {1'b0, alu_b};
    alu_y     = r[DATA_W-1:0];
    alu_flags = pack_flags(r[DATA_W-1], r[DATA_W-1:0] == '0, r[DATA_W], 1'b0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       output logic [DATA_W-1:0] eh, output logic [DATA_W-1:0] el,
                       output logic [FR_FLAG_W-1:0] ef);
    logic [2*DATA_W-1:0] p;
    if (op == MD_OP_MULU) begin
      p  = 32'(a) * 32'(b);
      eh = p[2*DATA_W-1:DATA_W];
      el = p[DATA_W-1:0];
      ef = pack_flags(el[DATA_W-1], p == 0, eh != 0, 1'b0);
    end else if (b == 0) begin
      eh = a;
      el = 16'hFFFF;
      ef = pack_flags(1'b1, 1'b0, 1'b0, 1'b1);
    end else begin
      el = a / b;
      eh = a % b;
      ef = pack_flags(el[DATA_W-1], el == 0, 1'b0, 1'b0);
    end
  endtask

  // Returns at the falling edge of the first cycle after acceptance
  task automatic start_op(input logic op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input string tag);
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = DATA_W'($urandom);
    req_b     = DATA_W'($urandom);
    req_op    = 1'($urandom);
  endtask

  task automatic do_op(input logic op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input int hold, input string tag);
    logic [DATA_W-1:0]    eh, el;
    logic [FR_FLAG_W-1:0] ef;
    int lat, own, exp_lat;
    model(op, a, b, eh, el, ef);
    exp_lat = (op == MD_OP_DIVU && b == 0) ? 1 : DATA_W + 1;
    start_op(op, a, b, tag);
    lat = 0;
    own = 0;
    for (int c = 1; c <= 40; c++) begin
      if (alu_own) own++;
      if (res_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_own_cycles"}, 32'(own), (exp_lat == 1) ? 32'd0 : 32'(DATA_W));
    check({tag, "_hi"}, 32'(res_hi), 32'(eh));
    check({tag, "_lo"}, 32'(res_lo), 32'(el));
    check({tag, "_flags"}, 32'(res_flags), 32'(ef));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_hold_res"}, {res_hi, res_lo}, {eh, el});
      check({tag, "_hold_flags"}, 32'(res_flags), 32'(ef));
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_release_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_release_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic watch_quiet(input string tag);
    int seen;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (res_valid || alu_own) seen++;
      @(negedge clk);
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic op;
    logic [DATA_W-1:0] a, b;

    repeat (3) @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_alu_own", 32'(alu_own), 32'd0);
    check("rst_alu_ab", {alu_a, alu_b}, 32'd0);
    check("rst_alu_func", 32'(alu_func), 32'(ALU_ADD));
    check("rst_res", {res_hi, res_lo}, 32'd0);
    check("rst_flags", 32'(res_flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    do_op(MD_OP_MULU, 16'h1234, 16'h0010, 5, "mul_1234x10");
    do_op(MD_OP_MULU, 16'hFFFF, 16'hFFFF, 0, "mul_ffffxffff");
    do_op(MD_OP_MULU, 16'h0000, 16'h5A5A, 0, "mul_zero");
    do_op(MD_OP_DIVU, 16'hFFFF, 16'h0007, 0, "div_ffff_7");
    do_op(MD_OP_DIVU, 16'h0005, 16'h8000, 0, "div_5_8000");
    do_op(MD_OP_DIVU, 16'h1234, 16'h0000, 2, "div_by_zero");

    start_op(MD_OP_DIVU, 16'hABCD, 16'h0033, "abort");
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_alu_own", 32'(alu_own), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_res_valid", 32'(res_valid), 32'd0);
    check("abort_alu_ab", {alu_a, alu_b}, 32'd0);
    watch_quiet("abort_quiet");

    start_op(MD_OP_DIVU, 16'h9876, 16'h0101, "midrst");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_alu_own", 32'(alu_own), 32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_alu_func", 32'(alu_func), 32'(ALU_ADD));
    check("midrst_res", {res_hi, res_lo}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("midrst_quiet");

    do_op(MD_OP_MULU, 16'h0003, 16'h0004, 0, "mul_3x4");
    check("mul_3x4_lo_direct", 32'(res_lo), 32'h000C);

    for (int i = 0; i < 24; i++) begin
      op = 1'($urandom);
      a  = DATA_W'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = DATA_W'($urandom_range(1, 15));
        default: b = DATA_W'($urandom);
      endcase
      do_op(op, a, b, $urandom_range(0, 2), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
